// File: rtl/johnson_pkg.sv
// johnson_pkg: shared Johnson-code helpers for the RTL and reference models.
// Functions: johnson_code(k, width) gives the code at phase index k,
// is_legal_johnson(code, width) gives 1 when code lies on the 2*width ring,
// johnson_phase(code, width) gives the phase index of a legal code (0 otherwise).
package johnson_pkg;
    localparam int MAX_WIDTH = 32;
    function automatic logic [31:0] johnson_code(input int k, input int width);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF >> (MAX_WIDTH - width);
        // First half fills ones from the MSB end, second half drains them toward the LSB end.
        return (k <= width) ? (mask & ~(mask >> k)) : (mask >> (k - width));
    endfunction
    function automatic logic is_legal_johnson(input logic [31:0] code, input int width);
        logic legal;
        legal = 1'b0;
        for (int k = 0; k < 2 * MAX_WIDTH; k++)
            if (k < 2 * width && code == johnson_code(k, width)) legal = 1'b1;
        return legal;
    endfunction
    function automatic logic [31:0] johnson_phase(input logic [31:0] code, input int width);
        logic [31:0] idx;
        idx = '0;
        for (int k = 0; k < 2 * MAX_WIDTH; k++)
            if (k < 2 * width && code == johnson_code(k, width)) idx = k[31:0];
        return idx;
    endfunction
endpackage

// File: rtl/johnson_decode.sv
// johnson_decode: combinational map from a Johnson code to its legality and phase index.
// Ports: code_i (candidate code), legal_o (code is on the ring), phase_o (index 0..2*WIDTH-1).
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] code_i,
    output logic             legal_o,
    output logic [PW-1:0]    phase_o
);
    assign legal_o = is_legal_johnson(32'(code_i), WIDTH);
    assign phase_o = PW'(johnson_phase(32'(code_i), WIDTH));
endmodule

// File: rtl/johnson_ctr.sv
// johnson_ctr: free-running twisted-ring counter with phase index, wrap pulse and self-correction.
// Ports: clk, rstn (sync reset, active high), out (ring state), phase (binary index),
// wrap (pulse when out returns to zero), illegal (pulse after a bad code was corrected).
module johnson_ctr
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             illegal
);
    logic [WIDTH-1:0] out_q, out_d, step;
    logic [PW-1:0]    phase_q, phase_d, step_phase;
    logic             wrap_q, wrap_d, illegal_q, illegal_d, step_legal;
    assign step = {~out_q[0], out_q[WIDTH-1:1]};
    // The ring step is a bijection that keeps the legal set closed, so the stepped
    // code is legal exactly when the current one is; decoding it yields both the
    // correction decision and the next phase in one lookup.
    johnson_decode #(.WIDTH(WIDTH), .PW(PW)) u_dec (
        .code_i  (step),
        .legal_o (step_legal),
        .phase_o (step_phase)
    );
    always_comb begin
        out_d     = (rstn || !step_legal) ? '0 : step;
        phase_d   = (rstn || !step_legal) ? '0 : step_phase;
        wrap_d    = !rstn && out_q == WIDTH'(1);
        illegal_d = !rstn && !step_legal;
    end
    always_ff @(posedge clk) begin
        if (rstn) begin
            out_q     <= '0;
            phase_q   <= '0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            phase_q   <= phase_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
        end
    end
    assign out     = out_q;
    assign phase   = phase_q;
    assign wrap    = wrap_q;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_johnson_ctr.sv
// tb_johnson_ctr: scoreboard bench for johnson_ctr at WIDTH=4 plus a WIDTH=2/5/8 sweep.
module tb_johnson_ctr;
    import johnson_pkg::*;
    typedef struct packed {
        logic [3:0] o;
        logic [2:0] p;
        logic       w;
        logic       i;
    } exp_t;
    logic clk, rstn, rst_s;
    logic [3:0] out;
    logic [2:0] phase;
    logic wrap, illegal;
    logic [1:0] o2; logic [1:0] p2; logic w2, i2;
    logic [4:0] o5; logic [3:0] p5; logic w5, i5;
    logic [7:0] o8; logic [3:0] p8; logic w8, i8;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int m_k = 0;
    johnson_ctr #(.WIDTH(4)) dut (.clk(clk), .rstn(rstn), .out(out), .phase(phase), .wrap(wrap), .illegal(illegal));
    johnson_ctr #(.WIDTH(2)) u2 (.clk(clk), .rstn(rst_s), .out(o2), .phase(p2), .wrap(w2), .illegal(i2));
    johnson_ctr #(.WIDTH(5)) u5 (.clk(clk), .rstn(rst_s), .out(o5), .phase(p5), .wrap(w5), .illegal(i5));
    johnson_ctr #(.WIDTH(8)) u8 (.clk(clk), .rstn(rst_s), .out(o8), .phase(p8), .wrap(w8), .illegal(i8));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // Independent reference: build the code for index k bit by bit.
    function automatic logic [31:0] code_of(input int k, input int w);
        logic [31:0] c;
        c = '0;
        for (int b = 0; b < w; b++)
            c[b] = (k <= w) ? (b >= w - k) : (b < 2 * w - k);
        return c;
    endfunction
    // Push the expected result of one edge, then apply rstn and clock it.
    task automatic drive(input logic r, input logic bad);
        exp_t e;
        logic [31:0] c;
        int k;
        e.w = 1'b0;
        e.i = 1'b0;
        if (r) k = 0;
        else if (bad) begin k = 0; e.i = 1'b1; end
        else begin e.w = (m_k == 7); k = (m_k + 1) % 8; end
        c = code_of(k, 4);
        e.o = c[3:0];
        e.p = k[2:0];
        m_k = k;
        q.push_back(e);
        @(negedge clk);
        rstn = r;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        exp_t e, g;
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, 1'b0);
            g = {out, phase, wrap, illegal};
            e = q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL reset[%0d] got %b want %b", n, g, e); end
        end
    endtask
    task automatic test_count();
        exp_t e, g;
        for (int n = 0; n < 15; n++) begin
            drive(1'b0, 1'b0);
            g = {out, phase, wrap, illegal};
            e = q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL count[%0d] got %b want %b", n, g, e); end
        end
    endtask
    task automatic test_wrap();
        exp_t e, g;
        int wraps, last;
        wraps = 0;
        last = -1;
        for (int n = 0; n < 16; n++) begin
            drive(1'b0, 1'b0);
            g = {out, phase, wrap, illegal};
            e = q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL wrap_step[%0d] got %b want %b", n, g, e); end
            if (wrap === 1'b1) begin
                checks++;
                if (last >= 0 && n - last != 8) begin errors++; $display("FAIL wrap_spacing got %0d want 8", n - last); end
                last = n;
                wraps++;
            end
        end
        checks++;
        if (wraps != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", wraps); end
    endtask
    task automatic test_mid_reset();
        exp_t e, g;
        logic r;
        for (int n = 0; n < 8; n++) begin
            r = (n == 0 || n == 6);
            drive(r, 1'b0);
            g = {out, phase, wrap, illegal};
            e = q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL mid_reset[%0d] got %b want %b", n, g, e); end
        end
    endtask
    task automatic test_illegal();
        exp_t e, g;
        force dut.out_q = 4'b0101;
        #1;
        release dut.out_q;
        for (int n = 0; n < 2; n++) begin
            drive(1'b0, n == 0);
            g = {out, phase, wrap, illegal};
            e = q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL illegal[%0d] got %b want %b", n, g, e); end
        end
    endtask
    task automatic test_hold_reset();
        exp_t e, g;
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, 1'b0);
            g = {out, phase, wrap, illegal};
            e = q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL hold_reset[%0d] got %b want %b", n, g, e); end
        end
    endtask
    task automatic test_sweep();
        int ws[3] = '{2, 5, 8};
        int ks[3] = '{0, 0, 0};
        logic [31:0] go[3], gp[3];
        logic gw[3], gi[3];
        logic ew;
        @(negedge clk);
        rst_s = 1'b1;
        for (int n = 0; n < 33; n++) begin
            @(posedge clk);
            #1;
            go[0] = 32'(o2); gp[0] = 32'(p2); gw[0] = w2; gi[0] = i2;
            go[1] = 32'(o5); gp[1] = 32'(p5); gw[1] = w5; gi[1] = i5;
            go[2] = 32'(o8); gp[2] = 32'(p8); gw[2] = w8; gi[2] = i8;
            for (int j = 0; j < 3; j++) begin
                ew = (n > 0) && (ks[j] == 0) && (n >= 2 * ws[j]);
                checks++;
                if (go[j] !== code_of(ks[j], ws[j]) || gp[j] !== 32'(ks[j]) || gw[j] !== ew || gi[j] !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_w%0d[%0d] got out=%h phase=%0d wrap=%b illegal=%b want out=%h phase=%0d wrap=%b illegal=0",
                             ws[j], n, go[j], gp[j], gw[j], gi[j], code_of(ks[j], ws[j]), ks[j], ew);
                end
                checks++;
                if (!is_legal_johnson(go[j], ws[j]) || johnson_phase(go[j], ws[j]) !== gp[j]) begin
                    errors++;
                    $display("FAIL sweep_pkg_w%0d[%0d] got out=%h phase=%0d", ws[j], n, go[j], gp[j]);
                end
                ks[j] = (ks[j] + 1) % (2 * ws[j]);
            end
            @(negedge clk);
            rst_s = 1'b0;
        end
    endtask
    initial begin
        rstn = 1'b1;
        rst_s = 1'b1;
        test_reset();
        test_count();
        test_wrap();
        test_mid_reset();
        test_illegal();
        test_hold_reset();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
